// File: rtl/threshold_monitor_pkg.sv
// Shared types and constants for the threshold monitor.
// Holds the FSM state encodings and the debounce counter width.
package threshold_monitor_pkg;

  localparam int DCNT_W = 4;

  typedef enum logic [2:0] {
    NORMAL  = 3'd0,
    PEND_HI = 3'd1,
    HIGH    = 3'd2,
    PEND_LO = 3'd3,
    LOW     = 3'd4
  } state_t;

endpackage

// File: rtl/comparator_4bit.sv
// Unsigned 4-bit magnitude comparator.
// Reports a > b and a < b.
module comparator_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       gt,
  output logic       lt
);

  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/threshold_monitor_4bit.sv
// Debounced high/low threshold monitor with hysteresis,
// config checking and a saturating alarm-entry counter.
module threshold_monitor_4bit
  import threshold_monitor_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [3:0] sample,
  input  logic [3:0] thresh_hi,
  input  logic [3:0] thresh_lo,
  input  logic       cnt_clr,
  output logic [2:0] state,
  output logic       alarm_hi,
  output logic       alarm_lo,
  output logic       in_range,
  output logic       cfg_err,
  output logic [7:0] event_count
);

  localparam logic [DCNT_W:0] DB = (DCNT_W+1)'(DEBOUNCE);

  state_t            cur;
  state_t            nxt;
  logic [DCNT_W-1:0] dcnt;
  logic [DCNT_W-1:0] dn;
  logic [DCNT_W:0]   dinc;
  logic              db_hit;

  logic above, below_hi;
  logic below, above_lo;
  logic thr_gt, thr_lt;
  logic cfg_bad;
  logic entry;

  comparator_4bit u_cmp_hi (
    .a  (sample),
    .b  (thresh_hi),
    .gt (above),
    .lt (below_hi)
  );

  comparator_4bit u_cmp_lo (
    .a  (sample),
    .b  (thresh_lo),
    .gt (above_lo),
    .lt (below)
  );

  comparator_4bit u_cmp_cfg (
    .a  (thresh_hi),
    .b  (thresh_lo),
    .gt (thr_gt),
    .lt (thr_lt)
  );

  assign cfg_bad = thr_lt & ~thr_gt;
  assign dinc    = {1'b0, dcnt} + 1'b1;
  assign db_hit  = (dinc == DB);
  assign state   = cur;

  always_comb begin
    nxt = cur;
    dn  = dcnt;
    // Bad thresholds override everything, even without a sample.
    if (cfg_bad || cfg_err) begin
      nxt = NORMAL;
      dn  = '0;
    end else if (sample_valid) begin
      unique case (cur)
        NORMAL: begin
          dn = '0;
          if (above) begin
            if (DB == 1) nxt = HIGH;
            else begin
              nxt = PEND_HI;
              dn  = 1;
            end
          end else if (below) begin
            if (DB == 1) nxt = LOW;
            else begin
              nxt = PEND_LO;
              dn  = 1;
            end
          end
        end
        PEND_HI: begin
          if (above) begin
            if (db_hit) begin
              nxt = HIGH;
              dn  = '0;
            end else begin
              dn = dinc[DCNT_W-1:0];
            end
          end else begin
            nxt = NORMAL;
            dn  = '0;
          end
        end
        PEND_LO: begin
          if (below) begin
            if (db_hit) begin
              nxt = LOW;
              dn  = '0;
            end else begin
              dn = dinc[DCNT_W-1:0];
            end
          end else begin
            nxt = NORMAL;
            dn  = '0;
          end
        end
        HIGH: begin
          if (below_hi) nxt = NORMAL;
        end
        LOW: begin
          if (above_lo) nxt = NORMAL;
        end
        default: begin
          nxt = NORMAL;
          dn  = '0;
        end
      endcase
    end
  end

  assign entry = ((nxt == HIGH) && (cur != HIGH))
              || ((nxt == LOW) && (cur != LOW));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur         <= NORMAL;
      dcnt        <= '0;
      alarm_hi    <= 1'b0;
      alarm_lo    <= 1'b0;
      in_range    <= 1'b1;
      cfg_err     <= 1'b0;
      event_count <= '0;
    end else begin
      cur      <= nxt;
      dcnt     <= dn;
      alarm_hi <= (nxt == HIGH);
      alarm_lo <= (nxt == LOW);
      in_range <= (nxt != HIGH) && (nxt != LOW) && !cfg_bad;
      cfg_err  <= cfg_bad;
      if (cnt_clr) begin
        event_count <= entry ? 8'd1 : 8'd0;
      end else if (entry && (event_count != 8'hff)) begin
        event_count <= event_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_threshold_monitor_4bit.sv
// Directed scoreboard bench for threshold_monitor_4bit
// (DEBOUNCE=3, thresh_hi=10, thresh_lo=3 by default).
module tb_threshold_monitor_4bit;

  logic       clk;
  logic       rst;
  logic       sample_valid;
  logic [3:0] sample;
  logic [3:0] thresh_hi;
  logic [3:0] thresh_lo;
  logic       cnt_clr;
  logic [2:0] state;
  logic       alarm_hi;
  logic       alarm_lo;
  logic       in_range;
  logic       cfg_err;
  logic [7:0] event_count;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0] st;
    logic       ah;
    logic       al;
    logic       ir;
    logic       ce;
    logic [7:0] ec;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];

  threshold_monitor_4bit #(.DEBOUNCE(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .thresh_hi    (thresh_hi),
    .thresh_lo    (thresh_lo),
    .cnt_clr      (cnt_clr),
    .state        (state),
    .alarm_hi     (alarm_hi),
    .alarm_lo     (alarm_lo),
    .in_range     (in_range),
    .cfg_err      (cfg_err),
    .event_count  (event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input string tag, input logic [2:0] st,
                          input logic ah, input logic al,
                          input logic ir, input logic ce,
                          input logic [7:0] ec);
    obs_t e;
    e = '{st: st, ah: ah, al: al, ir: ir, ce: ce, ec: ec};
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    obs_t  e;
    obs_t  o;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = '{st: state, ah: alarm_hi, al: alarm_lo, ir: in_range,
          ce: cfg_err, ec: event_count};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed st=%0d ah=%b al=%b ir=%b ce=%b ec=%0d expected st=%0d ah=%b al=%b ir=%b ce=%b ec=%0d",
             t, o.st, o.ah, o.al, o.ir, o.ce, o.ec,
             e.st, e.ah, e.al, e.ir, e.ce, e.ec);
    end
  endtask

  task automatic check_dcnt(input string tag, input logic [3:0] exp_d);
    checks++;
    assert (dut.dcnt === exp_d) else begin
      errors++;
      $error("FAIL %s: observed dcnt=%0d expected dcnt=%0d",
             tag, dut.dcnt, exp_d);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] s, input logic c,
                      input string tag, input logic [2:0] st,
                      input logic ah, input logic al, input logic ir,
                      input logic ce, input logic [7:0] ec);
    sample_valid = v;
    sample       = s;
    cnt_clr      = c;
    push_exp(tag, st, ah, al, ir, ce, ec);
    @(posedge clk);
    #1;
    pop_check();
    cnt_clr = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [3:0] s);
    sample_valid = v;
    sample       = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    sample_valid = 1'b0;
    sample       = 4'd0;
    thresh_hi    = 4'd10;
    thresh_lo    = 4'd3;
    cnt_clr      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push_exp("reset", 3'd0, 0, 0, 1, 0, 8'd0);
    pop_check();
    rst = 1'b0;

    // high alarm with hysteresis
    step(1, 4'd11, 0, "hi_s1", 3'd1, 0, 0, 1, 0, 8'd0);
    step(1, 4'd11, 0, "hi_s2", 3'd1, 0, 0, 1, 0, 8'd0);
    step(1, 4'd11, 0, "hi_s3", 3'd2, 1, 0, 0, 0, 8'd1);
    step(1, 4'd10, 0, "hi_hold", 3'd2, 1, 0, 0, 0, 8'd1);
    step(1, 4'd9,  0, "hi_clear", 3'd0, 0, 0, 1, 0, 8'd1);

    // interrupted debounce
    step(1, 4'd11, 0, "int_s1", 3'd1, 0, 0, 1, 0, 8'd1);
    step(1, 4'd11, 0, "int_s2", 3'd1, 0, 0, 1, 0, 8'd1);
    step(1, 4'd5,  0, "int_brk", 3'd0, 0, 0, 1, 0, 8'd1);
    step(1, 4'd11, 0, "int_s4", 3'd1, 0, 0, 1, 0, 8'd1);
    check_dcnt("int_dcnt", 4'd1);
    step(1, 4'd5,  0, "int_back", 3'd0, 0, 0, 1, 0, 8'd1);

    // low alarm with invalid gaps
    step(1, 4'd2, 0, "lo_s1", 3'd3, 0, 0, 1, 0, 8'd1);
    for (int i = 0; i < 4; i++)
      step(0, 4'd0, 0, "lo_gap", 3'd3, 0, 0, 1, 0, 8'd1);
    check_dcnt("lo_gap_dcnt", 4'd1);
    step(1, 4'd2, 0, "lo_s2", 3'd3, 0, 0, 1, 0, 8'd1);
    step(1, 4'd2, 0, "lo_s3", 3'd4, 0, 1, 0, 0, 8'd2);
    step(1, 4'd3, 0, "lo_hold", 3'd4, 0, 1, 0, 0, 8'd2);
    step(1, 4'd4, 0, "lo_clear", 3'd0, 0, 0, 1, 0, 8'd2);

    // config error while in HIGH
    step(1, 4'd11, 0, "cfg_s1", 3'd1, 0, 0, 1, 0, 8'd2);
    step(1, 4'd11, 0, "cfg_s2", 3'd1, 0, 0, 1, 0, 8'd2);
    step(1, 4'd11, 0, "cfg_s3", 3'd2, 1, 0, 0, 0, 8'd3);
    thresh_lo = 4'd12;
    step(1, 4'd11, 0, "cfg_err", 3'd0, 0, 0, 0, 1, 8'd3);
    thresh_lo = 4'd3;
    step(1, 4'd5, 0, "cfg_fix", 3'd0, 0, 0, 1, 0, 8'd3);

    // equal thresholds are legal
    thresh_lo = 4'd7;
    thresh_hi = 4'd7;
    step(1, 4'd7, 0, "thr_eq", 3'd0, 0, 0, 1, 0, 8'd3);
    thresh_lo = 4'd3;
    thresh_hi = 4'd10;

    // clear alone, then saturation
    step(0, 4'd0, 1, "clr_only", 3'd0, 0, 0, 1, 0, 8'd0);
    for (int i = 0; i < 255; i++) begin
      drive(1, 4'd11);
      drive(1, 4'd11);
      drive(1, 4'd11);
      drive(1, 4'd9);
    end
    step(0, 4'd0, 0, "cnt_255", 3'd0, 0, 0, 1, 0, 8'd255);
    drive(1, 4'd11);
    drive(1, 4'd11);
    step(1, 4'd11, 0, "cnt_sat", 3'd2, 1, 0, 0, 0, 8'd255);
    step(1, 4'd9,  0, "sat_exit", 3'd0, 0, 0, 1, 0, 8'd255);

    // clear coinciding with entry
    drive(1, 4'd11);
    drive(1, 4'd11);
    step(1, 4'd11, 1, "clr_entry", 3'd2, 1, 0, 0, 0, 8'd1);
    step(1, 4'd9,  0, "clr_exit", 3'd0, 0, 0, 1, 0, 8'd1);

    // asynchronous reset mid-debounce
    step(1, 4'd11, 0, "rst_pend", 3'd1, 0, 0, 1, 0, 8'd1);
    rst = 1'b1;
    #1;
    push_exp("rst_async", 3'd0, 0, 0, 1, 0, 8'd0);
    pop_check();
    check_dcnt("rst_dcnt", 4'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 4'd11, 0, "post_rst", 3'd1, 0, 0, 1, 0, 8'd0);
    check_dcnt("post_rst_dcnt", 4'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
